// File: rtl/mult_arb_pkg.sv
// Shared widths and FSM encoding for the shared-multiplier arbiter.
package mult_arb_pkg;
  localparam int A_W = 20;
  localparam int B_W = 8;
  localparam int P_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/TwentyBitMultiplier.sv
// Combinational 20x8 unsigned multiplier shared by all requesters.
module TwentyBitMultiplier (
  input  logic [19:0] i_a,
  input  logic [7:0]  i_b,
  output logic [27:0] o_p
);
  assign o_p = {8'd0, i_a} * {20'd0, i_b};
endmodule

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request at or above the pointer, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic               o_any_req,
  output logic [ID_W-1:0]    o_winner_id
);
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    logic [ID_W:0] s;
    s = {1'b0, base} + (ID_W+1)'(off);
    if (s >= (ID_W+1)'(NUM_REQ)) begin
      s = s - (ID_W+1)'(NUM_REQ);
    end else begin
      s = s;
    end
    return s[ID_W-1:0];
  endfunction

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    o_any_req   = 1'b0;
    o_winner_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[wrap_add(i_rr_ptr, k)]) begin
        o_any_req   = 1'b1;
        o_winner_id = wrap_add(i_rr_ptr, k);
      end else begin
        o_any_req   = o_any_req;
      end
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// Time-multiplexes one 20x8 multiplier among NUM_REQ requesters with round-robin
// arbitration; each operation takes IDLE->BUSY->DONE and pulses ack in DONE.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*A_W-1:0] a_in,
  input  logic [NUM_REQ*B_W-1:0] b_in,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   valid_out,
  output logic [ID_W-1:0]        grant_id,
  output logic [P_W-1:0]         product_out
);
  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic [A_W-1:0]      r_a;
  logic [B_W-1:0]      r_b;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_valid;
  logic [P_W-1:0]      r_product;

  logic                w_any_req;
  logic [ID_W-1:0]     w_winner_id;
  logic [A_W-1:0]      w_a_sel;
  logic [B_W-1:0]      w_b_sel;
  logic [P_W-1:0]      w_product;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_ack_onehot;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_req       (req),
    .i_rr_ptr    (r_rr_ptr),
    .o_any_req   (w_any_req),
    .o_winner_id (w_winner_id)
  );

  TwentyBitMultiplier u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_product)
  );

  assign w_a_sel      = a_in[w_winner_id*A_W +: A_W];
  assign w_b_sel      = b_in[w_winner_id*B_W +: B_W];
  assign w_ack_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
  assign w_ptr_nxt    = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY:    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, product register, ack/valid pulse and pointer advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_ack      <= '0;
      r_valid    <= 1'b0;
      r_product  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack   <= '0;
          r_valid <= 1'b0;
          if (w_any_req) begin
            r_a        <= w_a_sel;
            r_b        <= w_b_sel;
            r_grant_id <= w_winner_id;
          end
        end
        // ack is registered here so it is high exactly while the FSM sits in DONE.
        BUSY: begin
          r_product <= w_product;
          r_ack     <= w_ack_onehot;
          r_valid   <= 1'b1;
        end
        DONE: begin
          r_ack    <= '0;
          r_valid  <= 1'b0;
          r_rr_ptr <= w_ptr_nxt;
        end
        default: begin
          r_ack   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ack         = r_ack;
  assign valid_out   = r_valid;
  assign grant_id    = r_grant_id;
  assign product_out = r_product;
endmodule
